// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM access master and the sram_controller bench.
// Holds the FSM state encoding, default bus widths and the command word width.
package sram_pkg;

   localparam int unsigned DEF_AW = 4;
   localparam int unsigned DEF_DW = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sram_state_e;

   // Command word layout, MSB first: {we, addr[AW-1:0], wdata[DW-1:0]}
   function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
      return 1 + aw + dw;
   endfunction

endpackage

// File: rtl/sram_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full/empty are distinguishable.
module sram_cmd_fifo #(
   parameter int unsigned W     = 13,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wptr, rptr, wptr_n, rptr_n;
   logic         do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr[PW-1:0]];

   always_comb begin
      wptr_n = wptr + {{PW{1'b0}}, do_push};
      rptr_n = rptr + {{PW{1'b0}}, do_pop};
   end

   // Flags come from next-state pointers so they are registered yet current
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wptr  <= wptr_n;
         rptr  <= rptr_n;
         full  <= (wptr_n[PW] != rptr_n[PW]) && (wptr_n[PW-1:0] == rptr_n[PW-1:0]);
         empty <= (wptr_n == rptr_n);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/sram_access_master.sv
// Initiator side of the SRAM controller request interface: buffers host commands,
// issues them one at a time to the controller and returns one response per command.
module sram_access_master
   import sram_pkg::*;
#(
   parameter int unsigned AW      = DEF_AW,
   parameter int unsigned DW      = DEF_DW,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_we,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   localparam int unsigned    CW       = cmd_width(AW, DW);
   localparam int unsigned    TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  CNT_LAST = TW'(TIMEOUT - 1);

   sram_state_e   state, state_n;
   logic [CW-1:0] fifo_dout;
   logic          fifo_full, fifo_empty, pop;
   logic          hold_we;
   logic [AW-1:0] hold_addr;
   logic [DW-1:0] hold_wdata;
   logic [TW-1:0] cnt;
   logic          rsp_we_q, rsp_err_q;
   logic [DW-1:0] rsp_rdata_q;

   sram_cmd_fifo #(
      .W     (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (cmd_valid && cmd_ready),
      .din     ({cmd_we, cmd_addr, cmd_wdata}),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign pop       = (state == IDLE) && !fifo_empty;
   assign cmd_ready = !fifo_full;
   assign mem_rd    = (state == ISSUE) && !hold_we;
   assign mem_wr    = (state == ISSUE) && hold_we;
   assign mem_addr  = hold_addr;
   assign mem_wdata = hold_wdata;
   assign rsp_valid = (state == RESP);
   assign rsp_we    = rsp_we_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (!fifo_empty) state_n = ISSUE;
         ISSUE:   state_n = WAIT;
         WAIT:    if (mem_ready || cnt == CNT_LAST) state_n = RESP;
         RESP:    if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // cnt counts cycles since ISSUE, so the timeout response lands TIMEOUT cycles after the strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         hold_we     <= 1'b0;
         hold_addr   <= '0;
         hold_wdata  <= '0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state <= state_n;
         if (pop) {hold_we, hold_addr, hold_wdata} <= fifo_dout;
         if (state == IDLE || state == RESP) cnt <= '0;
         else if (state_n != RESP)           cnt <= cnt + TW'(1);
         if (state == WAIT && state_n == RESP) begin
            rsp_we_q    <= hold_we;
            rsp_err_q   <= !mem_ready;
            rsp_rdata_q <= (mem_ready && !hold_we) ? mem_rdata : '0;
         end
      end
   end

endmodule

// File: tb/tb_sram_access_master.sv
// Directed bench for sram_access_master with a small behavioural SRAM controller model.
module tb_sram_access_master;

   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cmd_valid, cmd_ready, cmd_we;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid, rsp_ready, rsp_we, rsp_err;
   logic [7:0] rsp_rdata;
   logic       mem_rd, mem_wr;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       mem_ready = 1'b0;

   int total = 0;
   int bad   = 0;
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

   // controller model state
   logic [7:0] sram [16];
   bit         mute = 0, spur_req = 0, busy = 0, cur_rd = 0;
   int         dly = 0;
   logic [3:0] cur_addr = '0;

   always #5 clk = ~clk;

   sram_access_master #(
      .AW      (4),
      .DW      (8),
      .DEPTH   (4),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   // Strobe monitor
   always @(negedge clk) begin
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      if (mem_rd && mem_wr) both_cnt++;
   end

   // Controller: one-cycle mem_ready pulse two cycles after the strobe
   always @(negedge clk) begin
      mem_ready = 1'b0;
      mem_rdata = 8'h00;
      if (!reset_n) begin
         busy = 0;
      end else begin
         if (spur_req) begin
            mem_ready = 1'b1;
            mem_rdata = 8'hEE;
            spur_req  = 0;
         end else if (busy) begin
            if (dly == 0) begin
               mem_ready = 1'b1;
               mem_rdata = cur_rd ? sram[cur_addr] : 8'h00;
               busy      = 0;
            end else dly--;
         end
         if ((mem_rd || mem_wr) && !mute) begin
            busy     = 1;
            dly      = 1;
            cur_rd   = mem_rd;
            cur_addr = mem_addr;
            if (mem_wr) sram[mem_addr] = mem_wdata;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push_cmd(input logic we, input logic [3:0] a, input logic [7:0] d, output bit ok);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (cmd_ready) ok = 1;
         tick(1);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic we, output logic [7:0] rd, output logic err, output bit ok);
      rsp_ready = 1'b1;
      ok = 0; we = 1'bx; rd = 'x; err = 1'bx;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (rsp_valid) begin
            ok = 1; we = rsp_we; rd = rsp_rdata; err = rsp_err;
         end
         tick(1);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h1; cmd_wdata = 8'h11;
      rsp_ready = 1'b0;
      tick(2);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      total++; if ({mem_rd, mem_wr} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {mem_rd, mem_wr}); end
      total++; if ({rsp_we, rsp_err, rsp_rdata, mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {rsp_we, rsp_err, rsp_rdata, mem_addr, mem_wdata}); end
      cmd_valid = 1'b0;
      reset_n   = 1'b1;
      tick(5);
      total++; if (rd_cnt + wr_cnt !== 0) begin bad++; $display("FAIL idle_no_strobe: got %0d want 0", rd_cnt + wr_cnt); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_rsp_valid: got %b want 0", rsp_valid); end
   endtask

   task automatic test_write_read;
      bit ok; logic we, err; logic [7:0] rd; int r0, w0;
      r0 = rd_cnt; w0 = wr_cnt;
      push_cmd(1'b1, 4'h4, 8'h5A, ok);
      get_rsp(we, rd, err, ok);
      total++; if (!ok || {we, err, rd} !== {1'b1, 1'b0, 8'h00}) begin bad++; $display("FAIL wr_rsp: got ok=%0d we=%b err=%b rd=%h want we=1 err=0 rd=00", ok, we, err, rd); end
      total++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin bad++; $display("FAIL wr_strobe_cycles: got wr=%0d rd=%0d want 1 0", wr_cnt - w0, rd_cnt - r0); end
      push_cmd(1'b0, 4'h4, 8'hFF, ok);
      get_rsp(we, rd, err, ok);
      total++; if (!ok || {we, err, rd} !== {1'b0, 1'b0, 8'h5A}) begin bad++; $display("FAIL rd_rsp: got ok=%0d we=%b err=%b rd=%h want we=0 err=0 rd=5a", ok, we, err, rd); end
      total++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin bad++; $display("FAIL rd_strobe_cycles: got wr=%0d rd=%0d want 1 1", wr_cnt - w0, rd_cnt - r0); end
   endtask

   task automatic test_backpressure;
      bit ok; logic we, err; logic [7:0] rd;
      logic [3:0] aa [5] = '{4'h8, 4'h8, 4'h9, 4'h9, 4'h4};
      logic       ww [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] dd [5] = '{8'h33, 8'h00, 8'h44, 8'h00, 8'h00};
      logic [7:0] ex [5] = '{8'h00, 8'h33, 8'h00, 8'h44, 8'h5A};
      int acc = 0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_cmd(ww[i], aa[i], dd[i], ok);
         if (ok) acc++;
      end
      total++; if (acc !== 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", acc); end
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'hF; cmd_wdata = 8'hFF;
      tick(4);
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got %b want 0", cmd_ready); end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_pending: got %b want 1", rsp_valid); end
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         get_rsp(we, rd, err, ok);
         total++;
         if (!ok || {we, err, rd} !== {ww[i], 1'b0, ex[i]}) begin
            bad++; $display("FAIL bp_rsp%0d: got ok=%0d we=%b err=%b rd=%h want we=%b err=0 rd=%h", i, ok, we, err, rd, ww[i], ex[i]);
         end
      end
      tick(10);
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_drained: got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_timeout;
      bit ok, seen; logic we, err; logic [7:0] rd; int k, r0;
      mute = 1; r0 = rd_cnt; seen = 0; k = -1;
      push_cmd(1'b0, 4'h3, 8'h00, ok);
      for (int i = 0; i < 10 && !seen; i++) begin
         if (mem_rd) seen = 1; else tick(1);
      end
      if (seen) begin
         k = 0;
         while (!rsp_valid && k < 40) begin tick(1); k++; end
      end
      total++; if (k !== TIMEOUT) begin bad++; $display("FAIL to_latency: got %0d want %0d", k, TIMEOUT); end
      total++; if ({rsp_we, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 8'h00}) begin bad++; $display("FAIL to_rsp: got we=%b err=%b rd=%h want 0 1 00", rsp_we, rsp_err, rsp_rdata); end
      total++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL to_strobe: got %0d want 1", rd_cnt - r0); end
      get_rsp(we, rd, err, ok);
      mute = 0;
      push_cmd(1'b0, 4'h8, 8'h00, ok);
      get_rsp(we, rd, err, ok);
      total++; if (!ok || {we, err, rd} !== {1'b0, 1'b0, 8'h33}) begin bad++; $display("FAIL to_next: got ok=%0d we=%b err=%b rd=%h want 0 0 33", ok, we, err, rd); end
   endtask

   task automatic test_reset_mid;
      bit ok, seen; int r0, w0;
      mute = 1; seen = 0;
      push_cmd(1'b0, 4'h9, 8'h00, ok);
      for (int i = 0; i < 10 && !seen; i++) begin
         if (mem_rd) seen = 1;
         tick(1);
      end
      push_cmd(1'b1, 4'hA, 8'h77, ok);
      tick(1);
      #2 reset_n = 1'b0;
      #1;
      total++; if ({mem_rd, mem_wr, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rst_async_strobes: got %b want 000", {mem_rd, mem_wr, rsp_valid}); end
      total++; if (mem_addr !== 4'h0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_async_regs: got addr=%h ready=%b want 0 1", mem_addr, cmd_ready); end
      r0 = rd_cnt; w0 = wr_cnt;
      tick(2);
      reset_n = 1'b1; mute = 0;
      tick(20);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp: got %b want 0", rsp_valid); end
      total++; if (rd_cnt !== r0 || wr_cnt !== w0) begin bad++; $display("FAIL rst_flushed: got rd=%0d wr=%0d want %0d %0d", rd_cnt, wr_cnt, r0, w0); end
   endtask

   task automatic test_spurious;
      bit ok; logic we, err; logic [7:0] rd; int r0, w0;
      r0 = rd_cnt; w0 = wr_cnt;
      spur_req = 1;
      tick(4);
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL spur_state: got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
      total++; if (rd_cnt !== r0 || wr_cnt !== w0) begin bad++; $display("FAIL spur_strobes: got rd=%0d wr=%0d want %0d %0d", rd_cnt, wr_cnt, r0, w0); end
      push_cmd(1'b0, 4'h8, 8'h00, ok);
      get_rsp(we, rd, err, ok);
      total++; if (!ok || {we, err, rd} !== {1'b0, 1'b0, 8'h33}) begin bad++; $display("FAIL spur_next: got ok=%0d we=%b err=%b rd=%h want 0 0 33", ok, we, err, rd); end
      total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_exclusive: got %0d want 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_spurious();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
